// File: rtl/mem_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the arbiter state encoding, the requester identity used by the
// round-robin picker, the memory geometry and the memory map constants.
package mem_pkg;

    localparam int DEPTH_C = 256;
    localparam int WORD_W  = 16;

    // Memory map: fetch starts at RESET_VEC, the interrupt vector lives at IRQ_VEC_PTR.
    localparam logic [15:0] RESET_VEC   = 16'd16;
    localparam logic [15:0] IRQ_VEC_PTR = 16'd2;

    typedef enum logic [2:0] {
        ST_ARB   = 3'd0,
        ST_I_RD  = 3'd1,
        ST_I_RET = 3'd2,
        ST_D_RD  = 3'd3,
        ST_D_RET = 3'd4,
        ST_D_WR  = 3'd5
    } state_e;

    typedef enum logic {
        LAST_I = 1'b0,
        LAST_D = 1'b1
    } last_e;

    // States in which the memory is free for a new access during the next cycle.
    function automatic logic is_grant_state(input state_e s);
        return (s == ST_ARB) || (s == ST_I_RET) || (s == ST_D_RET) || (s == ST_D_WR);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester picker (fetch vs. data) with a last-grant register.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   en              - a grant may be issued this cycle
//   req_i, req_d    - fetch / data requests
//   gnt_i, gnt_d    - combinational one-hot grant
// DATA_PRIORITY=0 alternates on contention, 1 lets data always win.
// last_grant resets to data so that fetch wins the first contention.
module rr_pick2
    import mem_pkg::*;
#(
    parameter int DATA_PRIORITY = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_i,
    input  logic req_d,
    output logic gnt_i,
    output logic gnt_d
);

    last_e last_q;
    last_e last_d;
    logic  gnt_i_s;
    logic  gnt_d_s;

    // Grant decision and next value of the last-grant record.
    always_comb begin
        gnt_i_s = 1'b0;
        gnt_d_s = 1'b0;
        if (en) begin
            if (req_i && req_d) begin
                if (DATA_PRIORITY != 0) begin
                    gnt_d_s = 1'b1;
                end else if (last_q == LAST_D) begin
                    gnt_i_s = 1'b1;
                end else begin
                    gnt_d_s = 1'b1;
                end
            end else if (req_i) begin
                gnt_i_s = 1'b1;
            end else if (req_d) begin
                gnt_d_s = 1'b1;
            end else begin
                gnt_i_s = 1'b0;
            end
        end else begin
            gnt_d_s = 1'b0;
        end

        if (gnt_i_s) begin
            last_d = LAST_I;
        end else if (gnt_d_s) begin
            last_d = LAST_D;
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_D;
        end else begin
            last_q <= last_d;
        end
    end

    assign gnt_i = gnt_i_s;
    assign gnt_d = gnt_d_s;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer for the single-port 256x16 unified memory, shared
// between the instruction-fetch unit (if_*) and the load/store unit (dm_*).
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt          - fetch request handshake (gnt combinational)
//   if_rvalid/if_rdata             - registered fetch response
//   dm_req/dm_we/dm_addr/dm_wdata  - data request, dm_gnt combinational
//   dm_rvalid/dm_rdata             - registered data response
//   err                            - out-of-range flag, pulses with an rvalid
//   i_read,d_read,d_write,i_push,d_push, i_addr,d_addr - memory controls
//   i_bus                          - memory instruction output
//   d_bus                          - shared data bus, driven here only in D_WR
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16,
    parameter int DEPTH         = DEPTH_C,
    parameter int DATA_PRIORITY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              err,
    output logic              i_read,
    output logic              d_read,
    output logic              d_write,
    output logic              i_push,
    output logic              d_push,
    output logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] i_bus,
    inout  wire  [DATA_W-1:0] d_bus
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic              err_q, err_d;
    logic              i_read_q, d_read_q, d_write_q, i_push_q, d_push_q;
    logic              en_s, gnt_i_s, gnt_d_s, i_oor_s, d_oor_s;

    assign en_s    = is_grant_state(state_q);
    assign i_oor_s = ({1'b0, if_addr} >= DEPTH_L);
    assign d_oor_s = ({1'b0, dm_addr} >= DEPTH_L);

    rr_pick2 #(
        .DATA_PRIORITY (DATA_PRIORITY)
    ) u_pick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_s),
        .req_i (if_req),
        .req_d (dm_req),
        .gnt_i (gnt_i_s),
        .gnt_d (gnt_d_s)
    );

    // Next-state, capture of returned data and new-grant latching.
    always_comb begin
        state_d     = state_q;
        i_addr_d    = i_addr_q;
        d_addr_d    = d_addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_ARB:   state_d = ST_ARB;
            ST_I_RD:  state_d = ST_I_RET;
            ST_I_RET: begin
                if_rdata_d  = i_bus;
                if_rvalid_d = 1'b1;
                state_d     = ST_ARB;
            end
            ST_D_RD:  state_d = ST_D_RET;
            ST_D_RET: begin
                dm_rdata_d  = d_bus;
                dm_rvalid_d = 1'b1;
                state_d     = ST_ARB;
            end
            ST_D_WR: begin
                dm_rvalid_d = 1'b1;
                state_d     = ST_ARB;
            end
            default:  state_d = ST_ARB;
        endcase

        // A grant overrides the return to ARB so back-to-back accesses need no idle cycle.
        // Out-of-range accesses skip the memory entirely and answer next cycle with err.
        if (gnt_i_s) begin
            i_addr_d = if_addr;
            if (i_oor_s) begin
                state_d     = ST_ARB;
                if_rvalid_d = 1'b1;
                err_d       = 1'b1;
                if_rdata_d  = {DATA_W{1'b0}};
            end else begin
                state_d = ST_I_RD;
            end
        end else if (gnt_d_s) begin
            d_addr_d = dm_addr;
            we_d     = dm_we;
            wdata_d  = dm_wdata;
            if (d_oor_s) begin
                state_d     = ST_ARB;
                dm_rvalid_d = 1'b1;
                err_d       = 1'b1;
                if (!dm_we) begin
                    dm_rdata_d = {DATA_W{1'b0}};
                end else begin
                    dm_rdata_d = dm_rdata_q;
                end
            end else begin
                state_d = dm_we ? ST_D_WR : ST_D_RD;
            end
        end else begin
            we_d = we_q;
        end
    end

    // FSM state, latched request, responses and strobes decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARB;
            i_addr_q    <= {ADDR_W{1'b0}};
            d_addr_q    <= {ADDR_W{1'b0}};
            we_q        <= 1'b0;
            wdata_q     <= {DATA_W{1'b0}};
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
            err_q       <= 1'b0;
            i_read_q    <= 1'b0;
            i_push_q    <= 1'b0;
            d_read_q    <= 1'b0;
            d_push_q    <= 1'b0;
            d_write_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_addr_q    <= i_addr_d;
            d_addr_q    <= d_addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
            err_q       <= err_d;
            i_read_q    <= (state_d == ST_I_RD);
            i_push_q    <= (state_d == ST_I_RET);
            d_read_q    <= (state_d == ST_D_RD);
            d_push_q    <= (state_d == ST_D_RET);
            d_write_q   <= (state_d == ST_D_WR);
        end
    end

    assign if_gnt    = gnt_i_s;
    assign dm_gnt    = gnt_d_s;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rvalid = dm_rvalid_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
    assign i_read    = i_read_q;
    assign i_push    = i_push_q;
    assign d_read    = d_read_q;
    assign d_push    = d_push_q;
    assign d_write   = d_write_q;
    assign i_addr    = i_addr_q;
    assign d_addr    = d_addr_q;

    // The memory only drives d_bus during d_push, which never coincides with D_WR.
    assign d_bus = d_write_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
    logic [15:0] if_addr = 16'h0, dm_addr = 16'h0, dm_wdata = 16'h0;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, err;
    logic [15:0] if_rdata, dm_rdata, i_addr, d_addr, i_bus;
    logic        i_read, d_read, d_write, i_push, d_push;
    wire  [15:0] d_bus;

    // second instance with data priority; only its grants are observed
    logic        p_if_req = 1'b0, p_dm_req = 1'b0;
    logic        p_if_gnt, p_if_rvalid, p_dm_gnt, p_dm_rvalid, p_err;
    logic [15:0] p_if_rdata, p_dm_rdata, p_i_addr, p_d_addr;
    logic        p_i_read, p_d_read, p_d_write, p_i_push, p_d_push;
    wire  [15:0] p_d_bus;

    int          n_checks = 0, n_fail = 0, cyc = 0;
    int          n_iread = 0, n_ipush = 0, n_strobes = 0, n_excl = 0, n_stray = 0;
    exp_t        exp_if[$];
    exp_t        exp_dm[$];
    logic [15:0] dm_last = 16'h0;
    logic [15:0] cur_wdata = 16'h0;
    logic [15:0] mem [256];
    logic [15:0] i_lat = 16'h0, d_lat = 16'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_PRIORITY(0)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .err(err),
        .i_read(i_read), .d_read(d_read), .d_write(d_write), .i_push(i_push), .d_push(d_push),
        .i_addr(i_addr), .d_addr(d_addr), .i_bus(i_bus), .d_bus(d_bus)
    );

    mem_arbiter #(.DATA_PRIORITY(1)) u_dut_p (
        .clk(clk), .rst_n(rst_n),
        .if_req(p_if_req), .if_addr(16'd16), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
        .dm_req(p_dm_req), .dm_we(1'b0), .dm_addr(16'd2), .dm_wdata(16'h0000), .dm_gnt(p_dm_gnt),
        .dm_rvalid(p_dm_rvalid), .dm_rdata(p_dm_rdata), .err(p_err),
        .i_read(p_i_read), .d_read(p_d_read), .d_write(p_d_write), .i_push(p_i_push), .d_push(p_d_push),
        .i_addr(p_i_addr), .d_addr(p_d_addr), .i_bus(16'h0000), .d_bus(p_d_bus)
    );

    // memory model: acts mid-cycle, drives the buses during the push cycle
    assign i_bus = i_push ? i_lat : 16'h0000;
    assign d_bus = d_push ? d_lat : 16'hzzzz;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h1234;
        mem[2]  = 16'h0017;
        mem[16] = 16'hFF10;
        mem[17] = 16'h0000;
        forever begin
            @(negedge clk);
            if (i_read)  i_lat = mem[i_addr[7:0]];
            if (d_read)  d_lat = mem[d_addr[7:0]];
            if (d_write) mem[d_addr[7:0]] = d_bus;
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_if(input logic [15:0] d, input logic e);
        exp_t x;
        x.data = e ? 16'h0000 : d;
        x.err  = e;
        x.cyc  = cyc + (e ? 1 : 3);
        exp_if.push_back(x);
    endtask

    task automatic push_dm(input logic we, input logic [15:0] d, input logic e);
        exp_t x;
        x.data = we ? dm_last : (e ? 16'h0000 : d);
        if (!we) dm_last = x.data;
        x.err = e;
        x.cyc = cyc + (e ? 1 : (we ? 2 : 3));
        exp_dm.push_back(x);
    endtask

    // scoreboard monitor and bus/strobe invariants
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (if_rvalid) begin
                    check("if_rvalid_expected", exp_if.size() != 0, 1);
                    if (exp_if.size() != 0) begin
                        x = exp_if.pop_front();
                        check("if_rdata", if_rdata, x.data);
                        check("if_err", err, x.err);
                        check("if_latency", cyc, x.cyc);
                    end
                end
                if (dm_rvalid) begin
                    check("dm_rvalid_expected", exp_dm.size() != 0, 1);
                    if (exp_dm.size() != 0) begin
                        x = exp_dm.pop_front();
                        check("dm_rdata", dm_rdata, x.data);
                        check("dm_err", err, x.err);
                        check("dm_latency", cyc, x.cyc);
                    end
                end
                if (err && !if_rvalid && !dm_rvalid) check("err_without_rvalid", err, 0);
                if (d_write) check("d_bus_write", d_bus, cur_wdata);
                if ((32'(i_read) + 32'(d_read) + 32'(d_write)) > 1 || (d_write && d_push)) n_excl++;
                if (!d_write && !d_push && d_bus == 16'hBEEF) n_stray++;
                n_iread   += 32'(i_read);
                n_ipush   += 32'(i_push);
                n_strobes += 32'(i_read) + 32'(i_push) + 32'(d_read) + 32'(d_push) + 32'(d_write);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_if.delete();
        exp_dm.delete();
        dm_last = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_fetch(input logic [15:0] addr, input logic [15:0] d, input logic e);
        bit got = 0;
        @(negedge clk);
        if_req = 1'b1;
        if_addr = addr;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (if_gnt) begin got = 1; break; end
            @(negedge clk);
        end
        check("if_gnt_seen", got, 1);
        if (got) push_if(d, e);
        @(posedge clk);
        #1 if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                           input logic [15:0] d, input logic e);
        bit got = 0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = wd;
        cur_wdata = wd;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (dm_gnt) begin got = 1; break; end
            @(negedge clk);
        end
        check("dm_gnt_seen", got, 1);
        if (got) push_dm(we, d, e);
        @(posedge clk);
        #1 dm_req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 50 && (exp_if.size() + exp_dm.size()) != 0; k++) @(negedge clk);
        check("responses_drained", exp_if.size() + exp_dm.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int s0, r0, p0, cnt_i, cnt_d;
        int seq[$];
        bit got;

        // reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_strobes", {i_read, i_push, d_read, d_push, d_write}, 0);
        check("rst_gnt", {if_gnt, dm_gnt}, 0);
        check("rst_rvalid_err", {if_rvalid, dm_rvalid, err}, 0);
        check("rst_if_rdata", if_rdata, 16'h0000);
        check("rst_dm_rdata", dm_rdata, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_strobes", n_strobes, 0);

        // fetch after reset
        r0 = n_iread; p0 = n_ipush;
        do_fetch(16'd16, 16'hFF10, 1'b0);
        wait_idle();
        check("fetch_i_read_cycles", n_iread - r0, 1);
        check("fetch_i_push_cycles", n_ipush - p0, 1);

        // data read, write then read back
        do_data(1'b0, 16'd2, 16'h0000, 16'h0017, 1'b0);
        wait_idle();
        do_data(1'b1, 16'd40, 16'hBEEF, 16'h0000, 1'b0);
        wait_idle();
        do_data(1'b0, 16'd40, 16'h0000, 16'hBEEF, 1'b0);
        wait_idle();

        // out of range read and write
        s0 = n_strobes;
        do_data(1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1);
        wait_idle();
        do_data(1'b1, 16'h0100, 16'h5555, 16'h0000, 1'b1);
        wait_idle();
        do_fetch(16'h0100, 16'h0000, 1'b1);
        wait_idle();
        check("oor_no_strobes", n_strobes - s0, 0);
        do_data(1'b0, 16'd0, 16'h0000, 16'h1234, 1'b0);
        wait_idle();

        // contention, round robin, starting with fetch after reset
        do_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'd16;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'd2;
        for (int i = 0; i < 30 && seq.size() < 4; i++) begin
            #1;
            if (if_gnt) begin push_if(16'hFF10, 1'b0); seq.push_back(0); end
            if (dm_gnt) begin push_dm(1'b0, 16'h0017, 1'b0); seq.push_back(1); end
            @(negedge clk);
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("rr_grant_count", seq.size(), 4);
        for (int i = 0; i < seq.size(); i++) check("rr_grant_order", seq[i], i % 2);
        wait_idle();

        // contention, data priority instance
        cnt_i = 0; cnt_d = 0;
        @(negedge clk);
        p_if_req = 1'b1; p_dm_req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            cnt_i += 32'(p_if_gnt);
            cnt_d += 32'(p_dm_gnt);
            @(negedge clk);
        end
        p_dm_req = 1'b0;
        check("prio_fetch_blocked", cnt_i, 0);
        check("prio_data_grants", cnt_d, 6);
        got = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            if (p_if_gnt) begin got = 1; break; end
            @(negedge clk);
        end
        check("prio_fetch_after_drop", got, 1);
        @(posedge clk);
        #1 p_if_req = 1'b0;
        repeat (4) @(negedge clk);

        // reset during I_RET drops the fetch
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'd16;
        got = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (if_gnt) begin got = 1; break; end
            @(negedge clk);
        end
        check("rstmid_gnt_seen", got, 1);
        @(posedge clk);
        #1 if_req = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid_i_push_before", i_push, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_i_push_cleared", i_push, 0);
        check("rstmid_no_rvalid", if_rvalid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_fetch(16'd17, 16'h0000, 1'b0);
        wait_idle();

        check("excl_violations", n_excl, 0);
        check("d_bus_stray_drive", n_stray, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
